// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with write-back bypass and a per-register pending-write scoreboard.
// Optional hazard-stall statistics counter enabled by defining SB_STALL_STATS_EN.

module sb_reg_slot #(
    parameter int XLEN = 32,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic            inc,
    output logic [XLEN-1:0] data,
    output logic [CNTW-1:0] cnt
);
    logic dec;

    // A write-back to an idle register still lands its data but must not wrap the counter.
    assign dec = we & (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else begin
            if (we)
                data <= wdata;
            if (inc & ~dec)
                cnt <= cnt + 1'b1;
            else if (dec & ~inc)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

module id_regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int CNTW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                issue_valid_i,
    input  logic                issue_flush_i,
    input  logic                issue_wr_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic [NRD*AW-1:0]   issue_rs_i,
    input  logic [NRD-1:0]      issue_use_i,
    output logic                issue_ready_o,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic                wb_en_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [XLEN-1:0]     wb_data_i,
    output logic [NREG-1:0]     busy_o,
    output logic                wb_err_o,
    output logic [31:0]         stall_cycles_o
);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0][CNTW-1:0] cnt;
    logic [NRD-1:0]            hazard;
    logic                      wb_fire;
    logic                      issue_fire;
    logic                      sat;

    assign wb_fire    = wb_en_i & ~stall_i & (wb_addr_i != '0);
    assign issue_fire = issue_valid_i & issue_ready_o & ~issue_flush_i & ~stall_i;

    assign regs[0]   = '0;
    assign cnt[0]    = '0;
    assign busy_o[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_slot
        sb_reg_slot #(.XLEN(XLEN), .CNTW(CNTW)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .we    (wb_fire & (wb_addr_i == AW'(r))),
            .wdata (wb_data_i),
            .inc   (issue_fire & issue_wr_i & (issue_rd_i == AW'(r))),
            .data  (regs[r]),
            .cnt   (cnt[r])
        );
        assign busy_o[r] = |cnt[r];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rs;
        logic          wb_hit;
        assign rs     = issue_rs_i[k*AW +: AW];
        assign wb_hit = wb_fire & (wb_addr_i == rs);
        assign rd_data_o[k*XLEN +: XLEN] = (rs == '0) ? '0 :
                                           wb_hit     ? wb_data_i : regs[rs];
        // The last outstanding write retiring this cycle resolves the operand via bypass.
        assign hazard[k] = issue_use_i[k] & (rs != '0) & (cnt[rs] != '0)
                         & ~(wb_hit & (cnt[rs] == CNTW'(1)));
    end

    assign sat = issue_wr_i & (issue_rd_i != '0) & (cnt[issue_rd_i] == '1)
               & ~(wb_fire & (wb_addr_i == issue_rd_i));

    assign issue_ready_o = ~|hazard & ~sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_err_o <= 1'b0;
        else if (wb_fire && cnt[wb_addr_i] == '0)
            wb_err_o <= 1'b1;
    end

`ifdef SB_STALL_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (issue_valid_i & ~issue_ready_o & ~stall_i & ~issue_flush_i & (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cycles_o = stall_cnt;
`else
    assign stall_cycles_o = 32'd0;
`endif
endmodule
